mem_ctrl: RTL and testbench

//  Arbiter and sequencer for the single byte-wide RAM port. It is shared by two requesters:
//   - the instruction cache miss-fill path (4-byte reads);
//   - the load/store unit (1-4 byte reads and writes).
//  A word access is split into sequential byte accesses. Read bytes are assembled

---
 rtl/mem_ctrl_pkg.sv | 38 +++
 rtl/mem_ctrl_if.sv | 58 +++++
 rtl/mem_rr_arbiter.sv | 42 ++++
 rtl/mem_ctrl.sv | 171 +++++++++++++++++
 tb/tb_mem_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared types and constants for the byte-wide RAM port sequencer
//
// Purpose: state encodings, grant identifiers, bus widths and the IO window
// prefix shared by mem_ctrl, its arbiter and its interface.
// Ports: none (package).
package mem_ctrl_pkg;

  localparam int         ADDR_W_DEFAULT    = 32;
  localparam logic [1:0] IO_PREFIX_DEFAULT = 2'b11;
  localparam int         WORD_W            = 32;
  localparam int         BYTE_W            = 8;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [BYTE_W-1:0] byte_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_RD_TAIL = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  typedef enum logic {
    GRANT_INST = 1'b0,
    GRANT_DATA = 1'b1
  } grant_t;

  // Byte count 1..4 -> index of the last byte; anything else is a full word.
  function automatic logic [1:0] len_to_last(input logic [2:0] len);
    case (len)
      3'd1:    return 2'd0;
      3'd2:    return 2'd1;
      3'd3:    return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// rtl/mem_ctrl_if.sv - requester and RAM-port signal bundle for mem_ctrl
//
// Purpose: groups the icache fill port, the LSU port, the IO-full flag and
// the byte-wide RAM port.
// Ports (signals):
//   inst_req/inst_addr/inst_data/inst_done          icache 4-byte fill
//   data_req/data_we/data_addr/data_len/data_wdata/
//   data_rdata/data_done                            LSU 1..4 byte access
//   io_full                                         IO buffer full
//   mem_a/mem_dout/mem_wr/mem_din                   byte-wide RAM port
// Modports: slave = controller view, master = requester/RAM view.
interface mem_ctrl_if
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT
);

  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  word_t             inst_data;
  logic              inst_done;

  logic              data_req;
  logic              data_we;
  logic [ADDR_W-1:0] data_addr;
  logic [2:0]        data_len;
  word_t             data_wdata;
  word_t             data_rdata;
  logic              data_done;

  logic              io_full;

  logic [ADDR_W-1:0] mem_a;
  byte_t             mem_dout;
  logic              mem_wr;
  byte_t             mem_din;

  modport slave (
    input  inst_req, inst_addr,
    output inst_data, inst_done,
    input  data_req, data_we, data_addr, data_len, data_wdata,
    output data_rdata, data_done,
    input  io_full,
    output mem_a, mem_dout, mem_wr,
    input  mem_din
  );

  modport master (
    output inst_req, inst_addr,
    input  inst_data, inst_done,
    output data_req, data_we, data_addr, data_len, data_wdata,
    input  data_rdata, data_done,
    output io_full,
    input  mem_a, mem_dout, mem_wr,
    output mem_din
  );

endinterface

// File: rtl/mem_rr_arbiter.sv
// rtl/mem_rr_arbiter.sv - two-way round-robin grant for the shared RAM port
//
// Purpose: picks icache or LSU when the port is free and remembers the
// most recent winner so that a tie goes to the other side next time.
// Ports:
//   clk, rst       clock, asynchronous active-low reset
//   req_inst       icache request
//   req_data       LSU request
//   take           controller accepts the current grant this cycle
//   grant          combinational winner for this cycle
//   last_grant     registered winner of the most recent take
module mem_rr_arbiter
  import mem_ctrl_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   req_inst,
  input  logic   req_data,
  input  logic   take,
  output grant_t grant,
  output grant_t last_grant
);

  always_comb begin
    grant = GRANT_INST;
    if (req_inst && req_data) begin
      grant = (last_grant == GRANT_INST) ? GRANT_DATA : GRANT_INST;
    end else if (req_data) begin
      grant = GRANT_DATA;
    end
  end

  // Reset value INST makes the LSU win the first tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant <= GRANT_INST;
    end else if (take) begin
      last_grant <= grant;
    end
  end

endmodule

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - arbiter and byte sequencer for the single byte-wide RAM port
//
// Purpose: serves icache 4-byte fills and LSU 1..4 byte reads/writes over a
// byte-wide RAM, one byte per cycle, assembling read bytes little-endian.
// IO-window write bytes wait while the IO buffer is full.
// Ports:
//   clk   system clock, all state on the rising edge
//   rst   asynchronous active-low reset
//   bus   mem_ctrl_if.slave: requester ports, io_full and RAM port
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int         ADDR_W    = ADDR_W_DEFAULT,
  parameter logic [1:0] IO_PREFIX = IO_PREFIX_DEFAULT
) (
  input logic       clk,
  input logic       rst,
  mem_ctrl_if.slave bus
);

  state_t            state;
  state_t            state_nx;
  grant_t            arb_grant;
  grant_t            cur_grant;
  logic              take;
  logic              any_req;
  logic              stall;
  logic              last_byte;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] cur_a;
  logic [1:0]        last_q;
  logic [1:0]        cnt_q;
  logic [1:0]        cap_idx;
  logic              we_q;
  word_t             wdata_q;
  word_t             buf_q;
  word_t             result_q;
  word_t             tail_word;

  assign any_req   = bus.inst_req | bus.data_req;
  assign take      = (state == ST_IDLE) && any_req;
  // Plain modular addition: running past all-ones wraps to zero.
  assign cur_a     = addr_q + ADDR_W'(cnt_q);
  assign last_byte = (cnt_q == last_q);
  assign stall     = (state == ST_RUN) && we_q &&
                     (cur_a[17:16] == IO_PREFIX) && bus.io_full;
  // RAM data lags its address by one cycle, so byte cnt-1 arrives now.
  assign cap_idx   = cnt_q - 2'd1;

  always_comb begin
    tail_word = buf_q;
    tail_word[{last_q, 3'b000} +: 8] = bus.mem_din;
  end

  // The arbiter's last_grant doubles as the owner of the current transaction.
  mem_rr_arbiter u_arb (
    .clk        (clk),
    .rst        (rst),
    .req_inst   (bus.inst_req),
    .req_data   (bus.data_req),
    .take       (take),
    .grant      (arb_grant),
    .last_grant (cur_grant)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (any_req) begin
          state_nx = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!stall && last_byte) begin
          state_nx = we_q ? ST_DONE : ST_RD_TAIL;
        end
      end
      ST_RD_TAIL: state_nx = ST_DONE;
      ST_DONE:    state_nx = ST_IDLE;
      default:    state_nx = ST_IDLE;
    endcase
  end

  // Outputs depend on state only through async-reset registers, so a reset
  // drops mem_wr immediately rather than at the next edge.
  always_comb begin
    bus.mem_a      = '0;
    bus.mem_dout   = '0;
    bus.mem_wr     = 1'b0;
    bus.inst_done  = 1'b0;
    bus.inst_data  = '0;
    bus.data_done  = 1'b0;
    bus.data_rdata = '0;
    case (state)
      ST_RUN: begin
        bus.mem_a  = cur_a;
        bus.mem_wr = we_q && !stall;
        if (we_q) begin
          bus.mem_dout = wdata_q[{cnt_q, 3'b000} +: 8];
        end
      end
      ST_DONE: begin
        if (cur_grant == GRANT_DATA) begin
          bus.data_done  = 1'b1;
          bus.data_rdata = result_q;
        end else begin
          bus.inst_done  = 1'b1;
          bus.inst_data  = result_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q   <= '0;
      last_q   <= '0;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      buf_q    <= '0;
      result_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            cnt_q    <= '0;
            // Cleared so unused upper bytes of a short read come out zero.
            buf_q    <= '0;
            result_q <= '0;
            if (arb_grant == GRANT_DATA) begin
              addr_q  <= bus.data_addr;
              last_q  <= len_to_last(bus.data_len);
              we_q    <= bus.data_we;
              wdata_q <= bus.data_wdata;
            end else begin
              addr_q  <= bus.inst_addr;
              last_q  <= 2'd3;
              we_q    <= 1'b0;
              wdata_q <= '0;
            end
          end
        end
        ST_RUN: begin
          if (!stall) begin
            cnt_q <= cnt_q + 2'd1;
            if (!we_q && (cnt_q != 2'd0)) begin
              buf_q[{cap_idx, 3'b000} +: 8] <= bus.mem_din;
            end
          end
        end
        ST_RD_TAIL: begin
          buf_q    <= tail_word;
          result_q <= tail_word;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - self-checking bench for mem_ctrl
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  localparam int NC = 64;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_ctrl_if #(.ADDR_W(32)) bus ();

  mem_ctrl #(.ADDR_W(32), .IO_PREFIX(2'b11)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  byte_t ram  [logic [31:0]];
  byte_t mref [logic [31:0]];

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] exp_a    [NC];
  bit          exp_wr   [NC];
  byte_t       exp_dout [NC];
  bit          exp_idone[NC];
  bit          exp_ddone[NC];
  bit          io_sched [NC];
  word_t       exp_idata;
  word_t       exp_ddata;
  bit          exp_dread;

  int    tcyc = 0;
  bit    chk_en = 1'b0;
  int    i_start = -1;
  int    d_start = -1;
  bit    seen_i, seen_d;
  int    i_done_cyc, d_done_cyc, i_done_cnt, d_done_cnt, wr_cnt;
  word_t i_data_seen, d_data_seen;

  function automatic byte_t ram_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : 8'h00;
  endfunction

  function automatic byte_t ref_rd(input logic [31:0] a);
    return mref.exists(a) ? mref[a] : 8'h00;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [31:0] a, input byte_t v);
    ram[a]  = v;
    mref[a] = v;
  endtask

  // RAM behaviour: address/strobe sampled mid-cycle, write and read-data
  // update at the edge, so read data appears the cycle after its address.
  logic [31:0] ram_a = '0;
  logic        ram_wr = 1'b0;
  byte_t       ram_d = '0;
  always @(negedge clk) begin
    ram_a  = bus.mem_a;
    ram_wr = bus.mem_wr;
    ram_d  = bus.mem_dout;
  end
  always @(posedge clk) begin
    if (ram_wr) ram[ram_a] = ram_d;
    bus.mem_din <= ram_rd(ram_a);
  end

  // Transaction model: one byte per cycle from start+1, IO-window write
  // bytes wait on io_full, reads spend one extra cycle, then a done cycle.
  task automatic sched_xfer(input bit is_inst, input bit we, input logic [31:0] addr,
                            input int len, input word_t wdata, input int start,
                            output int done);
    int    n;
    int    cy;
    word_t acc;
    logic [31:0] a;
    n   = (len >= 1 && len <= 4) ? len : 4;
    cy  = start + 1;
    acc = '0;
    for (int k = 0; k < n; k++) begin
      a = addr + 32'(k);
      while (we && a[17:16] == 2'b11 && io_sched[cy]) begin
        exp_a[cy] = a;
        cy++;
      end
      exp_a[cy]  = a;
      exp_wr[cy] = we;
      if (we) begin
        exp_dout[cy] = wdata[8*k +: 8];
        mref[a] = wdata[8*k +: 8];
      end else begin
        acc = acc | (word_t'(ref_rd(a)) << (8*k));
      end
      cy++;
    end
    if (!we) cy++;
    done = cy;
    if (is_inst) begin
      exp_idone[cy] = 1'b1;
      exp_idata     = acc;
    end else begin
      exp_ddone[cy] = 1'b1;
      exp_ddata     = acc;
      exp_dread     = !we;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en && tcyc < NC) begin
      chk($sformatf("c%0d mem_wr", tcyc), 32'(bus.mem_wr), 32'(exp_wr[tcyc]));
      chk($sformatf("c%0d mem_a", tcyc), bus.mem_a, exp_a[tcyc]);
      if (exp_wr[tcyc]) chk($sformatf("c%0d mem_dout", tcyc), 32'(bus.mem_dout), 32'(exp_dout[tcyc]));
      chk($sformatf("c%0d inst_done", tcyc), 32'(bus.inst_done), 32'(exp_idone[tcyc]));
      chk($sformatf("c%0d data_done", tcyc), 32'(bus.data_done), 32'(exp_ddone[tcyc]));
      if (exp_idone[tcyc] && bus.inst_done)
        chk($sformatf("c%0d inst_data", tcyc), bus.inst_data, exp_idata);
      if (exp_ddone[tcyc] && bus.data_done && exp_dread)
        chk($sformatf("c%0d data_rdata", tcyc), bus.data_rdata, exp_ddata);
      if (bus.inst_done) begin
        if (!seen_i) i_done_cyc = tcyc;
        seen_i = 1'b1;
        i_done_cnt++;
        i_data_seen = bus.inst_data;
      end
      if (bus.data_done) begin
        if (!seen_d) d_done_cyc = tcyc;
        seen_d = 1'b1;
        d_done_cnt++;
        d_data_seen = bus.data_rdata;
      end
      if (bus.mem_wr) wr_cnt++;
    end
  end

  task automatic begin_test();
    chk_en = 1'b0;
    for (int i = 0; i < NC; i++) begin
      exp_a[i] = '0; exp_wr[i] = 1'b0; exp_dout[i] = '0;
      exp_idone[i] = 1'b0; exp_ddone[i] = 1'b0; io_sched[i] = 1'b0;
    end
    exp_idata = '0; exp_ddata = '0; exp_dread = 1'b0;
    seen_i = 1'b0; seen_d = 1'b0;
    i_done_cyc = -1; d_done_cyc = -1; i_done_cnt = 0; d_done_cnt = 0; wr_cnt = 0;
    i_data_seen = '0; d_data_seen = '0;
    i_start = -1; d_start = -1;
  endtask

  task automatic run_cycles(input int from, input int to);
    for (int c = from; c < to; c++) begin
      tcyc          = c;
      bus.io_full   = io_sched[c];
      bus.inst_req  = (i_start >= 0) && (c >= i_start) && !seen_i;
      bus.data_req  = (d_start >= 0) && (c >= d_start) && !seen_d;
      chk_en        = 1'b1;
      @(posedge clk);
      #1;
    end
    chk_en = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic set_data(input bit we, input logic [31:0] addr, input logic [2:0] len,
                          input word_t wdata);
    bus.data_we = we; bus.data_addr = addr; bus.data_len = len; bus.data_wdata = wdata;
  endtask

  int dn;

  initial begin
    bus.inst_req = 1'b0; bus.inst_addr = '0;
    bus.data_req = 1'b0; bus.data_we = 1'b0; bus.data_addr = '0;
    bus.data_len = '0; bus.data_wdata = '0; bus.io_full = 1'b0;
    bus.mem_din = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst mem_a", bus.mem_a, 32'h0);
    chk("rst mem_wr", 32'(bus.mem_wr), 32'h0);
    chk("rst mem_dout", 32'(bus.mem_dout), 32'h0);
    chk("rst inst_done", 32'(bus.inst_done), 32'h0);
    chk("rst data_done", 32'(bus.data_done), 32'h0);
    chk("rst inst_data", bus.inst_data, 32'h0);
    chk("rst data_rdata", bus.data_rdata, 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;

    // 1: icache fill
    preload(32'h100, 8'h11); preload(32'h101, 8'h22);
    preload(32'h102, 8'h33); preload(32'h103, 8'h44);
    begin_test();
    bus.inst_addr = 32'h100; i_start = 0;
    sched_xfer(1'b1, 1'b0, 32'h100, 4, '0, 0, dn);
    run_cycles(0, 10);
    chk("t1 done_cycle", 32'(i_done_cyc), 32'd6);
    chk("t1 inst_data", i_data_seen, 32'h44332211);
    chk("t1 wr_count", 32'(wr_cnt), 32'd0);

    // 2: two-byte write
    preload(32'h202, 8'h5A);
    begin_test();
    set_data(1'b1, 32'h200, 3'd2, 32'hAABBCCDD); d_start = 0;
    sched_xfer(1'b0, 1'b1, 32'h200, 2, 32'hAABBCCDD, 0, dn);
    run_cycles(0, 8);
    chk("t2 done_cycle", 32'(d_done_cyc), 32'd3);
    chk("t2 ram200", 32'(ram_rd(32'h200)), 32'h0DD);
    chk("t2 ram201", 32'(ram_rd(32'h201)), 32'h0CC);
    chk("t2 ram202", 32'(ram_rd(32'h202)), 32'h05A);

    // 3: simultaneous requests right after reset
    do_reset();
    preload(32'h120, 8'h01); preload(32'h121, 8'h02);
    preload(32'h122, 8'h03); preload(32'h123, 8'h04);
    begin_test();
    set_data(1'b1, 32'h210, 3'd1, 32'h00000077);
    bus.inst_addr = 32'h120; i_start = 0; d_start = 0;
    sched_xfer(1'b0, 1'b1, 32'h210, 1, 32'h00000077, 0, dn);
    sched_xfer(1'b1, 1'b0, 32'h120, 4, '0, dn + 1, dn);
    run_cycles(0, 14);
    chk("t3 data_done_cycle", 32'(d_done_cyc), 32'd2);
    chk("t3 inst_done_cycle", 32'(i_done_cyc), 32'd9);
    chk("t3 inst_done_count", 32'(i_done_cnt), 32'd1);
    chk("t3 data_done_count", 32'(d_done_cnt), 32'd1);
    chk("t3 inst_data", i_data_seen, 32'h04030201);

    // 4: IO-window write stalled by io_full
    begin_test();
    io_sched[2] = 1'b1; io_sched[3] = 1'b1; io_sched[4] = 1'b1;
    set_data(1'b1, 32'h30000, 3'd4, 32'h44332211); d_start = 0;
    sched_xfer(1'b0, 1'b1, 32'h30000, 4, 32'h44332211, 0, dn);
    run_cycles(0, 12);
    chk("t4 done_cycle", 32'(d_done_cyc), 32'd8);
    chk("t4 wr_count", 32'(wr_cnt), 32'd4);
    chk("t4 ram30003", 32'(ram_rd(32'h30003)), 32'h044);

    // 4b: IO-window read ignores io_full
    preload(32'h30010, 8'h5E); preload(32'h30011, 8'h6F);
    begin_test();
    for (int i = 0; i < NC; i++) io_sched[i] = 1'b1;
    set_data(1'b0, 32'h30010, 3'd2, '0); d_start = 0;
    sched_xfer(1'b0, 1'b0, 32'h30010, 2, '0, 0, dn);
    run_cycles(0, 8);
    chk("t4b done_cycle", 32'(d_done_cyc), 32'd4);
    chk("t4b rdata", d_data_seen, 32'h00006F5E);

    // 5: one-byte read at the top of the address space
    preload(32'hFFFFFFFF, 8'h80);
    begin_test();
    set_data(1'b0, 32'hFFFFFFFF, 3'd1, '0); d_start = 0;
    sched_xfer(1'b0, 1'b0, 32'hFFFFFFFF, 1, '0, 0, dn);
    run_cycles(0, 6);
    chk("t5 done_cycle", 32'(d_done_cyc), 32'd3);
    chk("t5 rdata", d_data_seen, 32'h00000080);

    // 5b: len 0 means 4, address wraps
    preload(32'hFFFFFFFE, 8'hA1); preload(32'h0, 8'hB2); preload(32'h1, 8'hC3);
    begin_test();
    set_data(1'b0, 32'hFFFFFFFE, 3'd0, '0); d_start = 0;
    sched_xfer(1'b0, 1'b0, 32'hFFFFFFFE, 0, '0, 0, dn);
    run_cycles(0, 10);
    chk("t5b done_cycle", 32'(d_done_cyc), 32'd6);
    chk("t5b rdata", d_data_seen, 32'hC3B280A1);

    // 5c: len 6 write means 4
    begin_test();
    set_data(1'b1, 32'h500, 3'd6, 32'h11223344); d_start = 0;
    sched_xfer(1'b0, 1'b1, 32'h500, 6, 32'h11223344, 0, dn);
    run_cycles(0, 8);
    chk("t5c done_cycle", 32'(d_done_cyc), 32'd5);
    chk("t5c ram503", 32'(ram_rd(32'h503)), 32'h011);

    // 6: reset in the middle of a write
    begin_test();
    set_data(1'b1, 32'h400, 3'd4, 32'h0D0C0B0A); d_start = 0;
    exp_a[1] = 32'h400; exp_wr[1] = 1'b1; exp_dout[1] = 8'h0A;
    exp_a[2] = 32'h401; exp_wr[2] = 1'b1; exp_dout[2] = 8'h0B;
    run_cycles(0, 3);
    d_start = -1; bus.data_req = 1'b0;
    #1 rst = 1'b0;
    #1;
    chk("t6 wr_abort", 32'(bus.mem_wr), 32'h0);
    chk("t6 a_abort", bus.mem_a, 32'h0);
    run_cycles(3, 6);
    rst = 1'b1;
    run_cycles(6, 14);
    chk("t6 done_count", 32'(d_done_cnt), 32'd0);
    chk("t6 wr_count", 32'(wr_cnt), 32'd2);

    // 7: fresh fill after reset
    begin_test();
    bus.inst_addr = 32'h100; i_start = 0;
    sched_xfer(1'b1, 1'b0, 32'h100, 4, '0, 0, dn);
    run_cycles(0, 10);
    chk("t7 done_cycle", 32'(i_done_cyc), 32'd6);
    chk("t7 inst_data", i_data_seen, 32'h44332211);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
